// File: rtl/serial_operand_sequencer_if.sv
// ============================================================================
// Module      : serial_operand_sequencer_if
// Description : Operation, serial-ALU and result signals of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_operand_sequencer_if;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_func;
    logic [5:0]  bit_pos;
    logic [3:0]  alu_func;
    logic        alu_op_a;
    logic        alu_op_b;
    logic        alu_carry_in;
    logic        alu_rst;
    logic        alu_result;
    logic        alu_slt;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    // Sequencer side
    modport slave (
        input  op_valid, op_a, op_b, op_func, alu_result, alu_slt, res_ready,
        output op_ready, bit_pos, alu_func, alu_op_a, alu_op_b, alu_carry_in,
        output alu_rst, res_valid, res_data
    );

    // Environment side: requester, serial ALU and result consumer
    modport master (
        output op_valid, op_a, op_b, op_func, alu_result, alu_slt, res_ready,
        input  op_ready, bit_pos, alu_func, alu_op_a, alu_op_b, alu_carry_in,
        input  alu_rst, res_valid, res_data
    );
endinterface

`default_nettype wire

// File: rtl/serial_operand_sequencer.sv
// ============================================================================
// Module      : serial_operand_sequencer
// Description : Feeds two 32-bit operands LSB-first to a bit-serial ALU and
//               reassembles the result. Optional abort input: SERIAL_SEQ_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_operand_sequencer (
    input  logic clk,
    input  logic rst_n,
`ifdef SERIAL_SEQ_ABORT_EN
    input  logic abort,
`endif
    serial_operand_sequencer_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_CMP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  r_state;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_res_data;
    logic [3:0]  r_func;
    logic [5:0]  r_bit_pos;

    logic w_accept;
    logic w_is_cmp;
    logic w_last_bit;
    logic w_abort;

`ifdef SERIAL_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept   = bus.op_valid && (r_state == S_IDLE);
    assign w_is_cmp   = (r_func[2:1] == 2'b01);
    assign w_last_bit = (r_bit_pos == 6'd31);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op_a     <= 32'd0;
            r_op_b     <= 32'd0;
            r_res_data <= 32'd0;
            r_func     <= 4'd0;
            r_bit_pos  <= 6'd0;
        end else if (w_abort) begin
            r_state   <= S_IDLE;
            r_bit_pos <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_a  <= bus.op_a;
                        r_op_b  <= bus.op_b;
                        r_func  <= bus.op_func;
                        r_state <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_bit_pos <= 6'd0;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_op_a     <= {1'b0, r_op_a[31:1]};
                    r_op_b     <= {1'b0, r_op_b[31:1]};
                    r_res_data <= {bus.alu_result, r_res_data[31:1]};
                    if (w_last_bit) begin
                        // Compares need one extra cycle for the ALU to settle its verdict
                        if (w_is_cmp) begin
                            r_bit_pos <= 6'd32;
                            r_state   <= S_CMP;
                        end else begin
                            r_bit_pos <= 6'd0;
                            r_state   <= S_DONE;
                        end
                    end else begin
                        r_bit_pos <= r_bit_pos + 6'd1;
                    end
                end
                S_CMP: begin
                    r_res_data <= {31'd0, bus.alu_slt};
                    r_bit_pos  <= 6'd0;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_bit_pos <= 6'd0;
                end
            endcase
        end
    end

    assign bus.op_ready     = (r_state == S_IDLE);
    assign bus.res_valid    = (r_state == S_DONE);
    assign bus.res_data     = r_res_data;
    assign bus.alu_rst      = (r_state == S_CLR);
    assign bus.alu_func     = r_func;
    assign bus.bit_pos      = r_bit_pos;
    assign bus.alu_op_a     = (r_state == S_SHIFT) && r_op_a[0];
    assign bus.alu_op_b     = (r_state == S_SHIFT) && r_op_b[0];
    assign bus.alu_carry_in = r_func[3] && (r_state == S_SHIFT) && (r_bit_pos == 6'd0);

endmodule

`default_nettype wire

// File: doc/serial_operand_sequencer.md
SERIAL_OPERAND_SEQUENCER -- requirements
Module: serial_operand_sequencer

Interface
REQ-001 SHALL have port clk  in  1  single rising-edge clock for all state.
REQ-002 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have port op_valid  in  1  operation request.
REQ-004 SHALL have port op_ready  out  1  sequencer can accept an operation; high only in IDLE.
REQ-005 SHALL have port op_a  in  32  operand A, captured on accept.
REQ-006 SHALL have port op_b  in  32  operand B, captured on accept.
REQ-007 SHALL have port op_func  in  4  ALU function code, captured on accept.
REQ-008 SHALL have port bit_pos  out  6  current serial bit index to the ALU.
REQ-009 SHALL have port alu_func  out  4  registered op_func to the ALU.
REQ-010 SHALL have ports alu_op_a, alu_op_b  out  1 each  current LSB-first operand bits.
REQ-011 SHALL have port alu_carry_in  out  1  carry injection pulse.
REQ-012 SHALL have port alu_rst  out  1  synchronous clear of the ALU carry/compare state.
REQ-013 SHALL have ports alu_result, alu_slt  in  1 each  serial result bit and compare result from the ALU.
REQ-014 SHALL have port res_valid  out  1  res_data holds a completed result.
REQ-015 SHALL have port res_ready  in  1  consumer takes the result.
REQ-016 SHALL have port res_data  out  32  assembled parallel result.

Function
REQ-017 SHALL implement states IDLE, CLR, SHIFT, CMP, DONE.
REQ-018 SHALL accept an operation when op_valid and op_ready are both high at a clk edge (cycle 0): latch op_a, op_b, op_func; go to CLR.
REQ-019 SHALL hold alu_rst high for exactly the one CLR cycle (cycle 1), then enter SHIFT with bit_pos=0.
REQ-020 SHALL, in SHIFT, drive alu_op_a/alu_op_b from bit 0 of the operand shift registers, shift both right each cycle, and increment bit_pos 0..31 (cycles 2..33).
REQ-021 SHALL drive alu_carry_in = alu_func[3] AND (state==SHIFT) AND (bit_pos==0); low otherwise.
REQ-022 SHALL capture each SHIFT cycle as res_data <= {alu_result, res_data[31:1]}, so bit 0 lands in res_data[0] after 32 shifts.
REQ-023 SHALL, when alu_func[2:1]==2'b01 (SLT/SLTU), enter CMP after bit_pos 31 with bit_pos=32 for one cycle, then set res_data = {31'b0, alu_slt} sampled in that cycle.
REQ-024 SHALL otherwise go from SHIFT directly to DONE; res_valid high in DONE only: from cycle 34 (non-compare) or cycle 35 (compare).
REQ-025 SHALL hold res_data, res_valid stable in DONE until res_ready is high at a clk edge, then return to IDLE.
REQ-026 SHALL ignore op_valid outside IDLE; op_ready SHALL be low in CLR, SHIFT, CMP, DONE.
REQ-027 SHALL drive bit_pos=0 and alu_op_a=alu_op_b=0 in IDLE, CLR, DONE.
REQ-028 SHALL treat res_ready outside DONE as don't-care.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-operation, immediately enter IDLE and clear operand registers, alu_func, bit_pos, res_data to 0; res_valid=0, alu_carry_in=0, alu_rst=0, op_ready=1.
REQ-030 SHALL discard any in-flight operation on reset; no result is produced for it.

Configuration
REQ-031 SHALL, with macro SERIAL_SEQ_ABORT_EN defined, add input abort (1 bit); abort high at a clk edge returns to IDLE from any state, clears res_valid, and has priority over accept and res_ready.
REQ-032 SHALL, without SERIAL_SEQ_ABORT_EN, have no abort port and no abort logic.

Verification
REQ-033 SHALL test ADD: op_a=5, op_b=3, op_func=4'b0000 accepted at cycle 0 -> res_valid at cycle 34, res_data=32'h00000008, alu_carry_in never high.
REQ-034 SHALL test SUB: op_a=3, op_b=5, op_func=4'b1000 -> alu_carry_in high only at bit_pos 0, res_data=32'hFFFFFFFE.
REQ-035 SHALL test SLT: op_a=32'hFFFFFFFF, op_b=1, op_func=4'b1010 -> bit_pos reaches 32, res_valid at cycle 35, res_data=32'h00000001; same with op_func=4'b1011 (SLTU) -> 32'h00000000.
REQ-036 SHALL test backpressure: res_ready low for 10 cycles after res_valid -> res_data stable, op_ready low, second op_valid ignored; res_ready high -> IDLE next cycle, second op then accepted.
REQ-037 SHALL test reset at bit_pos=17: rst_n low -> all outputs at reset values without a clk edge; a new op after release completes normally with alu_rst pulse.
REQ-038 SHALL test, with SERIAL_SEQ_ABORT_EN, abort at bit_pos=10 -> IDLE next cycle, res_valid never asserted for that op.
